// File: rtl/alu_arbiter_if.sv
// Requester-side channel of the ALU arbiter: request (op, a, b) and response (result, zero, err).
// Latency: none; this is only a signal bundle.
// Backpressure: valid/ready on both the request and the response direction.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              err;

    // Requester side
    modport master (
        output req_valid, op, a, b, rsp_ready,
        input  req_ready, rsp_valid, result, zero, err
    );

    // Arbiter side
    modport slave (
        input  req_valid, op, a, b, rsp_ready,
        output req_ready, rsp_valid, result, zero, err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Latency: accept at edge k, response valid after edge k+1; at least 3 cycles per transaction.
// Backpressure: a response is held until its requester takes it; no new request is accepted meanwhile.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      r0,
    alu_arbiter_if.slave      r1,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic                   ptr;        // requester favoured when both are valid
    logic                   win_any;
    logic                   win_id;
    logic                   accept;
    logic                   rsp_take;
    logic [1:0][DATA_W-1:0] res_q;
    logic [1:0]             zero_q;
    logic [1:0]             err_q;
    logic [1:0]             rvld_q;

    // Only the nine encodings the ALU implements produce a real result.
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op inside {OP_W'(4'b0000), OP_W'(4'b0001), OP_W'(4'b0010),
                          OP_W'(4'b0110), OP_W'(4'b0111), OP_W'(4'b1000),
                          OP_W'(4'b1001), OP_W'(4'b1010), OP_W'(4'b1101)};
    endfunction

    // Winner selection: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        win_any  = r0.req_valid | r1.req_valid;
        win_id   = (r0.req_valid && r1.req_valid) ? ptr : r1.req_valid;
        // rst_n gating keeps req_ready low while reset is held.
        accept   = rst_n && (state == IDLE) && win_any;
        rsp_take = grant_id ? r1.rsp_ready : r0.rsp_ready;
    end

    assign r0.req_ready = accept && !win_id;
    assign r1.req_ready = accept && win_id;

    assign r0.rsp_valid = rvld_q[0];
    assign r0.result    = res_q[0];
    assign r0.zero      = zero_q[0];
    assign r0.err       = err_q[0];
    assign r1.rsp_valid = rvld_q[1];
    assign r1.result    = res_q[1];
    assign r1.zero      = zero_q[1];
    assign r1.err       = err_q[1];

    // Transaction FSM: latch the winner, give the ALU one cycle, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            alu_op1  <= '0;
            alu_op2  <= '0;
            alu_sel  <= '0;
            grant_id <= 1'b0;
            busy     <= 1'b0;
            res_q    <= '0;
            zero_q   <= '0;
            err_q    <= '0;
            rvld_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        alu_sel  <= win_id ? r1.op : r0.op;
                        alu_op1  <= win_id ? r1.a  : r0.a;
                        alu_op2  <= win_id ? r1.b  : r0.b;
                        grant_id <= win_id;
                        ptr      <= !win_id;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // An illegal opcode never exposes whatever the ALU drives.
                    if (is_legal(alu_sel)) begin
                        res_q[grant_id]  <= alu_result;
                        zero_q[grant_id] <= alu_zero;
                        err_q[grant_id]  <= 1'b0;
                    end else begin
                        res_q[grant_id]  <= '0;
                        zero_q[grant_id] <= 1'b0;
                        err_q[grant_id]  <= 1'b1;
                    end
                    rvld_q[grant_id] <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rvld_q[grant_id] <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios, then random two-requester traffic.
// Latency: the scoreboard expects each response two cycles after its request handshake.
// Backpressure: random rsp_ready stalls in the random phase, plus one long directed stall.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) r0_if ();
    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) r1_if ();

    logic [DW-1:0] alu_op1, alu_op2, alu_result;
    logic [OW-1:0] alu_sel;
    logic          alu_zero, busy, grant_id;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .r0(r0_if), .r1(r1_if),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    // Requester-side drive and observation, indexed by requester id
    logic [1:0]         req_valid = '0;
    logic [1:0][3:0]    req_op = '0;
    logic [1:0][31:0]   req_a = '0;
    logic [1:0][31:0]   req_b = '0;
    logic [1:0]         rsp_ready = 2'b11;
    logic [1:0]         rdy_w, vld_w, zero_w, err_w;
    logic [1:0][31:0]   res_w;

    assign r0_if.req_valid = req_valid[0];
    assign r0_if.op        = req_op[0];
    assign r0_if.a         = req_a[0];
    assign r0_if.b         = req_b[0];
    assign r0_if.rsp_ready = rsp_ready[0];
    assign r1_if.req_valid = req_valid[1];
    assign r1_if.op        = req_op[1];
    assign r1_if.a         = req_a[1];
    assign r1_if.b         = req_b[1];
    assign r1_if.rsp_ready = rsp_ready[1];
    assign rdy_w  = {r1_if.req_ready, r0_if.req_ready};
    assign vld_w  = {r1_if.rsp_valid, r0_if.rsp_valid};
    assign zero_w = {r1_if.zero, r0_if.zero};
    assign err_w  = {r1_if.err, r0_if.err};
    assign res_w  = {r1_if.result, r0_if.result};

    // Behavioural ALU semantics (used both as the shared ALU and inside the reference)
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a >> b[4:0];
            4'b1001: return a << b[4:0];
            4'b1010: return $unsigned($signed(a) >>> b[4:0]);
            4'b1101: return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD};
    endfunction

    // Shared ALU: garbage on illegal codes so any leak into the response shows up
    always_comb begin
        alu_result = alu_fn(alu_sel, alu_op1, alu_op2);
        alu_zero   = legal(alu_sel) ? (alu_result == 32'd0) : 1'b1;
    end

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        e;
        int          acc;
    } exp_t;

    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t x;
        x.acc = acc;
        if (legal(op)) begin
            x.res = alu_fn(op, a, b);
            x.z   = (x.res == 32'd0);
            x.e   = 1'b0;
        end else begin
            x.res = 32'd0;
            x.z   = 1'b0;
            x.e   = 1'b1;
        end
        return x;
    endfunction

    exp_t exp_q [2][$];
    int   grant_log [$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    bit   rand_bp = 1'b0;
    bit   outstanding = 1'b0;
    int   last_grant = 1;      // tie goes to the requester that was not granted last
    bit [1:0] unexp_seen = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
            miscompares++;
        end
    endtask

    // Scoreboard / monitor: arbitration model, busy/grant, and response checking
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic er;
                er = !outstanding && ((&req_valid) ? (i != last_grant) : req_valid[i]);
                chk($sformatf("req_ready%0d", i), 64'(rdy_w[i]), 64'(er));
            end
            chk("busy", 64'(busy), 64'(outstanding));
            if (outstanding) chk("grant_id", 64'(grant_id), 64'(last_grant));
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && rdy_w[i]) begin
                    exp_q[i].push_back(ref_model(req_op[i], req_a[i], req_b[i], cyc));
                    outstanding = 1'b1;
                    last_grant  = i;
                    grant_log.push_back(i);
                    vectors++;
                end
            end
            if (&vld_w) begin
                $display("FAIL rsp_valid both requesters: got %b expected one-hot", vld_w);
                miscompares++;
            end
            for (int i = 0; i < 2; i++) begin
                if (!vld_w[i]) begin
                    unexp_seen[i] = 1'b0;
                end else if (exp_q[i].size() == 0) begin
                    if (!unexp_seen[i]) begin
                        $display("FAIL unexpected rsp%0d: got rsp_valid 1 expected 0", i);
                        miscompares++;
                    end
                    unexp_seen[i] = 1'b1;
                end else begin
                    exp_t x;
                    x = exp_q[i][0];
                    if (x.acc >= 0) begin
                        chk($sformatf("latency%0d", i), 64'(cyc - x.acc), 64'd2);
                        exp_q[i][0].acc = -1;
                    end
                    chk($sformatf("result%0d", i), 64'(res_w[i]), 64'(x.res));
                    chk($sformatf("zero%0d", i), 64'(zero_w[i]), 64'(x.z));
                    chk($sformatf("err%0d", i), 64'(err_w[i]), 64'(x.e));
                    if (rsp_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        outstanding = 1'b0;
                    end
                end
            end
        end
    end

    // Random response backpressure
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_bp) rsp_ready = 2'($urandom_range(0, 3));
    end

    task automatic send(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk);
        #1;
        req_valid[id] = 1'b1;
        req_op[id] = op;
        req_a[id] = a;
        req_b[id] = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy_w[id]) break;
            n++;
            if (n > 300) begin
                $display("FAIL send%0d timeout: got no req_ready expected handshake", id);
                miscompares++;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || outstanding) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            $display("FAIL drain timeout: got %0d/%0d pending expected 0", exp_q[0].size(), exp_q[1].size());
            miscompares++;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rsp_valid"}, 64'(vld_w), 64'd0);
        chk({tag, " req_ready"}, 64'(rdy_w), 64'd0);
        chk({tag, " result0"}, 64'(res_w[0]), 64'd0);
        chk({tag, " result1"}, 64'(res_w[1]), 64'd0);
        chk({tag, " zero"}, 64'(zero_w), 64'd0);
        chk({tag, " err"}, 64'(err_w), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " grant_id"}, 64'(grant_id), 64'd0);
        chk({tag, " alu_op1"}, 64'(alu_op1), 64'd0);
        chk({tag, " alu_op2"}, 64'(alu_op2), 64'd0);
        chk({tag, " alu_sel"}, 64'(alu_sel), 64'd0);
    endtask

    task automatic rand_stream(input int id, input int count);
        logic [3:0] legal_ops [9];
        logic [3:0] op;
        logic [31:0] a, b;
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD};
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 8)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            send(id, op, a, b);
        end
    endtask

    initial begin
        // Reset state, with requests already pending
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Tie from reset goes to r0, then strict alternation
        fork
            send(0, 4'b0000, 32'hF0, 32'h3C);
            send(1, 4'b0001, 32'hF0, 32'h3C);
        join
        fork
            for (int k = 0; k < 4; k++) send(0, 4'b0010, 32'(k), 32'(k + 1));
            for (int k = 0; k < 4; k++) send(1, 4'b1101, 32'(k), 32'hFF);
        join
        drain();
        chk("grant_log size", 64'(grant_log.size()), 64'd10);
        for (int k = 0; k < grant_log.size(); k++)
            chk($sformatf("grant_order[%0d]", k), 64'(grant_log[k]), 64'(k % 2));

        // Single-requester ADD and SUB-to-zero
        send(0, 4'b0010, 32'd5, 32'd7);
        drain();
        send(1, 4'b0110, 32'd3, 32'd3);
        drain();

        // Illegal opcode, then a legal one on the same requester
        send(0, 4'b0011, 32'd9, 32'd9);
        drain();
        send(0, 4'b1001, 32'd1, 32'd4);
        drain();

        // Held response blocks the other requester
        rsp_ready[1] = 1'b0;
        fork
            send(1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
            begin
                repeat (3) @(posedge clk);
                send(0, 4'b0000, 32'hAA, 32'h0F);
            end
            begin
                int n;
                n = 0;
                while (!vld_w[1] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("held rsp1 appears", 64'(vld_w[1]), 64'd1);
                repeat (10) @(posedge clk);
                #1;
                chk("busy during hold", 64'(busy), 64'd1);
                rsp_ready[1] = 1'b1;
            end
        join
        drain();

        // Reset while the ALU cycle is in flight
        send(0, 4'b0010, 32'd1, 32'd2);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_outputs("mid-reset");
        exp_q[0].delete();
        exp_q[1].delete();
        outstanding = 1'b0;
        last_grant  = 1;
        unexp_seen  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(posedge clk);

        // Random traffic with random response backpressure
        rand_bp = 1'b1;
        fork
            rand_stream(0, 30);
            rand_stream(1, 30);
        join
        rand_bp = 1'b0;
        #1;
        rsp_ready = 2'b11;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end
endmodule
